// File: rtl/regfile_pkg.sv
// Shared sizing and types for the general-purpose register array and its read-side logic.
package regfile_pkg;

  localparam int NUM_REGS   = 8;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // One-hot mask for a register address; register 0 never gets a bit.
  function automatic reg_mask_t addr_mask(input reg_addr_t addr);
    reg_mask_t m;
    m = '0;
    if (addr != '0) m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy vector for registers with a write in flight, plus the availability queries
// used by the operand fetch hazard check.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en_i,
  input  reg_addr_t set_addr_i,
  input  logic      clr_en_i,
  input  reg_addr_t clr_addr_i,
  input  reg_addr_t rs1_i,
  input  reg_addr_t rs2_i,
  input  reg_addr_t rd_i,
  output logic      rs1_avail_o,
  output logic      rs2_avail_o,
  output logic      rd_free_o
);

  reg_mask_t busy_q, busy_d;

  // Clear first so a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d = busy_d & ~addr_mask(clr_addr_i);
    if (set_en_i) busy_d = busy_d | addr_mask(set_addr_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign rs1_avail_o = !busy_q[rs1_i] || (clr_en_i && (clr_addr_i == rs1_i));
  assign rs2_avail_o = !busy_q[rs2_i] || (clr_en_i && (clr_addr_i == rs2_i));
  assign rd_free_o   = !busy_q[rd_i]  || (clr_en_i && (clr_addr_i == rd_i));

endmodule

// File: rtl/operand_fetch_unit.sv
// Read-side controller for the register array: hazard-checked operand fetch with
// write-back forwarding, and write strobes driven from the write-back port.
module operand_fetch_unit
  import regfile_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  reg_addr_t                            req_rs1,
  input  reg_addr_t                            req_rs2,
  input  reg_addr_t                            req_rd,
  input  logic                                 req_rd_we,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_data,
  input  logic                                 wb_valid,
  input  reg_addr_t                            wb_addr,
  input  reg_data_t                            wb_data,
  output reg_mask_t                            write_enable,
  output reg_data_t                            data_in,
  output logic                                 op_valid,
  input  logic                                 op_ready,
  output reg_data_t                            op_a,
  output reg_data_t                            op_b,
  output reg_addr_t                            op_rd,
  output logic                                 op_rd_we
);

  logic      rs1_avail, rs2_avail, rd_free;
  logic      hazard, accept, rd_tracked;
  logic      op_valid_q, op_rd_we_q;
  reg_data_t op_a_q, op_b_q, op_a_d, op_b_d;
  reg_addr_t op_rd_q;

  assign rd_tracked = req_rd_we && (req_rd != '0);
  assign hazard     = !rs1_avail || !rs2_avail || (rd_tracked && !rd_free);
  assign req_ready  = !hazard && (!op_valid_q || op_ready);
  assign accept     = req_valid && req_ready;

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en_i    (accept && rd_tracked),
    .set_addr_i  (req_rd),
    .clr_en_i    (wb_valid),
    .clr_addr_i  (wb_addr),
    .rs1_i       (req_rs1),
    .rs2_i       (req_rs2),
    .rd_i        (req_rd),
    .rs1_avail_o (rs1_avail),
    .rs2_avail_o (rs2_avail),
    .rd_free_o   (rd_free)
  );

  // Register 0 reads as zero and is never forwarded.
  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    if (req_rs1 != '0) begin
      if (wb_valid && (wb_addr == req_rs1)) op_a_d = wb_data;
      else                                  op_a_d = reg_data[req_rs1];
    end
    if (req_rs2 != '0) begin
      if (wb_valid && (wb_addr == req_rs2)) op_b_d = wb_data;
      else                                  op_b_d = reg_data[req_rs2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rd_q    <= '0;
      op_rd_we_q <= 1'b0;
    end else if (accept) begin
      op_valid_q <= 1'b1;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_rd_q    <= req_rd;
      op_rd_we_q <= req_rd_we;
    end else if (op_valid_q && op_ready) begin
      op_valid_q <= 1'b0;
    end
  end

  assign op_valid     = op_valid_q;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_rd        = op_rd_q;
  assign op_rd_we     = op_rd_we_q;
  assign write_enable = wb_valid ? addr_mask(wb_addr) : '0;
  assign data_in      = wb_data;

endmodule

// File: doc/operand_fetch_unit.md
# operand_fetch_unit

Read-side controller for the 8-entry general-purpose register array: accepts decoded instructions over a valid/ready handshake and fetches two source operands from the array's parallel read bus. It keeps a busy scoreboard of registers with writes in flight and stalls on hazards. It forwards same-cycle write-back data and drives the array's one-hot write enables and shared data input from the write-back port. It sits between the decode stage and the ALU/execute stage.

## Interface
- NUM_REGS, 8: register count; must be a power of two ≥ 2.
- DATA_WIDTH, 8: register and operand width.
- ADDR_WIDTH, $clog2(NUM_REGS): register address width. Derived; do not override.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- req_valid  in  1  decoded instruction present.
- req_ready  out  1  instruction accepted this cycle when high with req_valid.
- req_rs1, req_rs2  in  ADDR_WIDTH  source register addresses.
- req_rd  in  ADDR_WIDTH  destination register address.
- req_rd_we  in  1  instruction will write req_rd.
- reg_data  in  DATA_WIDTH × NUM_REGS  parallel read bus from the array.
- wb_valid  in  1  write-back this cycle.
- wb_addr  in  ADDR_WIDTH  write-back register.
- wb_data  in  DATA_WIDTH  write-back value.
- write_enable  out  NUM_REGS  one-hot write strobes to the array.
- data_in  out  DATA_WIDTH  shared write data to the array.
- op_valid  out  1  operands valid.
- op_ready  in  1  execute stage consumes operands.
- op_a, op_b  out  DATA_WIDTH  operands for rs1 and rs2.
- op_rd, op_rd_we  out  ADDR_WIDTH, 1  destination carried forward.

## Operation
- Register 0 reads as 0. It is never marked busy, never forwarded, and its write_enable bit is always 0.
- Scoreboard busy[NUM_REGS-1:0] tracks pending writes.
  - Set busy[req_rd] on accept when req_rd_we=1 and req_rd≠0.
  - Clear busy[wb_addr] when wb_valid=1.
  - If the same register is set and cleared in one cycle, set wins.
  - Write-back to a non-busy register still writes the array; the scoreboard does not change.
- A source is available when it is 0, or not busy, or wb_valid=1 with wb_addr equal to that source.
- Hazard: rs1 or rs2 is unavailable, or req_rd_we=1 with req_rd≠0 busy and not cleared by a write-back this cycle (one outstanding write per register).
- req_ready = !hazard && (!op_valid || op_ready). This is combinational.
- Operand select for each source, in priority order:
  1. 0 when the address is 0.
  2. wb_data when wb_valid=1 and wb_addr matches.
  3. reg_data[addr] otherwise.
- write_enable = wb_valid ? (1 << wb_addr) with bit 0 masked : 0. data_in = wb_data. Both are combinational.

## Timing
- Accept at edge N: op_a, op_b, op_rd, op_rd_we are registered and op_valid=1 from N+1. Latency is 1 cycle.
- The output register holds until op_valid && op_ready. Consume and new accept may happen in the same cycle with zero bubble.
- Output values are stable while op_valid=1 and op_ready=0.
- A write-back to a register already latched in op_a/op_b does not update the latched value. This cannot occur legally because the scoreboard prevents it.
- Reset (asynchronous assert, deassert synchronized externally):
  - op_valid=0, op_a=op_b=0, op_rd=0, op_rd_we=0.
  - busy=0.
  - write_enable follows wb_valid combinationally, so the driver must hold wb_valid=0 during reset.
- Reset asserted mid-stall drops the pending operands and clears all busy bits.

## Structure
- Shared package regfile_pkg holds NUM_REGS, DATA_WIDTH, ADDR_WIDTH, and a reg_addr_t typedef. The register array uses the same package.
- One sub-module, reg_scoreboard, holds the busy vector and its set/clear/query logic. Everything else stays in operand_fetch_unit.

## Test plan
- Reset, then a request with rs1=3, rs2=5, reg_data[3]=0x12, reg_data[5]=0x34 → op_valid next cycle with op_a=0x12, op_b=0x34.
- Request rs1=0, rs2=0 with reg_data[0]=0xFF driven → op_a=op_b=0x00. A write-back to address 0 → write_enable=0x00.
- Accept rd=4 with we=1; next request reads rs1=4 → req_ready=0 until wb_valid, wb_addr=4, wb_data=0xA5. In that cycle the request is accepted with op_a=0xA5 forwarded.
- A write-back clearing rd=2 in the same cycle a new rd=2 writer is accepted → busy[2] stays 1, and a later rs1=2 read stalls.
- Hold op_ready=0 for 3 cycles with op_valid=1 → req_ready=0 and outputs are unchanged. Raise op_ready with a queued request → consume and accept in one cycle with no bubble.
- Assert rst mid-stall with busy[6]=1 → op_valid=0 and busy=0 immediately. After release, a read of rs1=6 is accepted without a stall.
